// File: rtl/hazard_ctrl_pkg.sv
// Shared pipeline definitions for the hazard unit: register/forward widths, forward
// select encodings, stage-record layout and the forward-select priority helper.
package hazard_ctrl_pkg;

  localparam int REG_W     = 5;
  localparam int FWD_SEL_W = 2;
  localparam int CNT_W     = 32;

  typedef logic [REG_W-1:0]     reg_t;
  typedef logic [FWD_SEL_W-1:0] fwd_t;

  localparam fwd_t FWD_GRF = 2'd0;
  localparam fwd_t FWD_M   = 2'd1;
  localparam fwd_t FWD_W   = 2'd2;

  typedef struct packed {
    logic we;
    reg_t wa;
    logic lw;
    reg_t rs;
    reg_t rt;
    logic use_rs;
    logic use_rt;
  } stage_rec_t;

  localparam stage_rec_t BUBBLE = '0;

  // M wins over W, but a load still in M has no data yet, so it cannot forward.
  function automatic fwd_t fwd_sel(input logic hit_m, input logic hit_m_lw, input logic hit_w);
    fwd_t sel;
    sel = FWD_GRF;
    if (hit_m && !hit_m_lw) begin
      sel = FWD_M;
    end else if (hit_w) begin
      sel = FWD_W;
    end
    return sel;
  endfunction

endpackage

// File: rtl/hazard_match.sv
// Compares one source register against one stage record's destination; purely combinational.
// Register 0 never matches, and an unused source never matches.
module hazard_match
  import hazard_ctrl_pkg::*;
(
  input  logic src_use,
  input  reg_t src,
  input  logic rec_we,
  input  reg_t rec_wa,
  input  logic rec_lw,
  output logic hit,
  output logic hit_lw
);

  assign hit    = src_use && rec_we && (rec_wa == src) && (src != '0);
  assign hit_lw = hit && rec_lw;

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard unit: same-cycle stall and forward selects from E/M/W stage records; stall freezes
// PC and IF/ID and bubbles ID/EX. HAZARD_STAT_EN adds a saturating stall-cycle counter.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic [REG_W-1:0]     id_rs,
  input  logic [REG_W-1:0]     id_rt,
  input  logic                 id_use_rs,
  input  logic                 id_use_rt,
  input  logic                 id_early,
  input  logic                 id_we,
  input  logic [REG_W-1:0]     id_wa,
  input  logic                 id_lw,
  output logic                 stall,
  output logic [FWD_SEL_W-1:0] fwd_rs_d,
  output logic [FWD_SEL_W-1:0] fwd_rt_d,
  output logic [FWD_SEL_W-1:0] fwd_rs_e,
  output logic [FWD_SEL_W-1:0] fwd_rt_e,
  output logic [CNT_W-1:0]     stall_cnt
);

  stage_rec_t id_rec;
  stage_rec_t e_q;
  stage_rec_t m_q;
  stage_rec_t w_q;

  always_comb begin
    id_rec        = BUBBLE;
    id_rec.we     = id_we;
    id_rec.wa     = id_wa;
    id_rec.lw     = id_lw;
    id_rec.rs     = id_rs;
    id_rec.rt     = id_rt;
    id_rec.use_rs = id_use_rs;
    id_rec.use_rt = id_use_rt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      e_q <= BUBBLE;
      m_q <= BUBBLE;
      w_q <= BUBBLE;
    end else begin
      e_q <= stall ? BUBBLE : id_rec;
      m_q <= e_q;
      w_q <= m_q;
    end
  end

  logic d_rs_e_hit, d_rs_e_lw, d_rs_m_hit, d_rs_m_lw, d_rs_w_hit, d_rs_w_lw;
  logic d_rt_e_hit, d_rt_e_lw, d_rt_m_hit, d_rt_m_lw, d_rt_w_hit, d_rt_w_lw;
  logic x_rs_m_hit, x_rs_m_lw, x_rs_w_hit, x_rs_w_lw;
  logic x_rt_m_hit, x_rt_m_lw, x_rt_w_hit, x_rt_w_lw;

  // ID sources against E, M, W.
  hazard_match u_d_rs_e (
    .src_use (id_use_rs), .src (id_rs),
    .rec_we  (e_q.we),    .rec_wa (e_q.wa), .rec_lw (e_q.lw),
    .hit     (d_rs_e_hit), .hit_lw (d_rs_e_lw)
  );
  hazard_match u_d_rs_m (
    .src_use (id_use_rs), .src (id_rs),
    .rec_we  (m_q.we),    .rec_wa (m_q.wa), .rec_lw (m_q.lw),
    .hit     (d_rs_m_hit), .hit_lw (d_rs_m_lw)
  );
  hazard_match u_d_rs_w (
    .src_use (id_use_rs), .src (id_rs),
    .rec_we  (w_q.we),    .rec_wa (w_q.wa), .rec_lw (w_q.lw),
    .hit     (d_rs_w_hit), .hit_lw (d_rs_w_lw)
  );
  hazard_match u_d_rt_e (
    .src_use (id_use_rt), .src (id_rt),
    .rec_we  (e_q.we),    .rec_wa (e_q.wa), .rec_lw (e_q.lw),
    .hit     (d_rt_e_hit), .hit_lw (d_rt_e_lw)
  );
  hazard_match u_d_rt_m (
    .src_use (id_use_rt), .src (id_rt),
    .rec_we  (m_q.we),    .rec_wa (m_q.wa), .rec_lw (m_q.lw),
    .hit     (d_rt_m_hit), .hit_lw (d_rt_m_lw)
  );
  hazard_match u_d_rt_w (
    .src_use (id_use_rt), .src (id_rt),
    .rec_we  (w_q.we),    .rec_wa (w_q.wa), .rec_lw (w_q.lw),
    .hit     (d_rt_w_hit), .hit_lw (d_rt_w_lw)
  );

  // EX sources (held in the E record) against M and W.
  hazard_match u_x_rs_m (
    .src_use (e_q.use_rs), .src (e_q.rs),
    .rec_we  (m_q.we),     .rec_wa (m_q.wa), .rec_lw (m_q.lw),
    .hit     (x_rs_m_hit), .hit_lw (x_rs_m_lw)
  );
  hazard_match u_x_rs_w (
    .src_use (e_q.use_rs), .src (e_q.rs),
    .rec_we  (w_q.we),     .rec_wa (w_q.wa), .rec_lw (w_q.lw),
    .hit     (x_rs_w_hit), .hit_lw (x_rs_w_lw)
  );
  hazard_match u_x_rt_m (
    .src_use (e_q.use_rt), .src (e_q.rt),
    .rec_we  (m_q.we),     .rec_wa (m_q.wa), .rec_lw (m_q.lw),
    .hit     (x_rt_m_hit), .hit_lw (x_rt_m_lw)
  );
  hazard_match u_x_rt_w (
    .src_use (e_q.use_rt), .src (e_q.rt),
    .rec_we  (w_q.we),     .rec_wa (w_q.wa), .rec_lw (w_q.lw),
    .hit     (x_rt_w_hit), .hit_lw (x_rt_w_lw)
  );

  // Early consumers (beq/jr) cannot wait for EX forwarding; any consumer must wait out a load in E.
  logic early_stall;
  logic load_use_stall;

  always_comb begin
    early_stall    = 1'b0;
    load_use_stall = 1'b0;
    if (id_early && (d_rs_e_hit || d_rt_e_hit || d_rs_m_lw || d_rt_m_lw)) begin
      early_stall = 1'b1;
    end
    if (d_rs_e_lw || d_rt_e_lw) begin
      load_use_stall = 1'b1;
    end
    stall = early_stall || load_use_stall;
  end

  always_comb begin
    fwd_rs_d = fwd_sel(d_rs_m_hit, d_rs_m_lw, d_rs_w_hit);
    fwd_rt_d = fwd_sel(d_rt_m_hit, d_rt_m_lw, d_rt_w_hit);
    fwd_rs_e = fwd_sel(x_rs_m_hit, x_rs_m_lw, x_rs_w_hit);
    fwd_rt_e = fwd_sel(x_rt_m_hit, x_rt_m_lw, x_rt_w_hit);
  end

  // W only supplies a destination; its source fields and load flags towards W are never consulted.
  logic unused_w_bits;
  assign unused_w_bits = ^{w_q.rs, w_q.rt, w_q.use_rs, w_q.use_rt,
                           d_rs_w_lw, d_rt_w_lw, x_rs_w_lw, x_rt_w_lw};

`ifdef HAZARD_STAT_EN
  logic [CNT_W-1:0] stall_cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_q <= '0;
    end else if (stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_q <= stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign stall_cnt = stall_cnt_q;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed hazard scenarios followed by random instruction streams, checked against an
// in-flight-instruction queue model of the pipeline.
module tb_hazard_ctrl;

  typedef struct packed {
    logic       we;
    logic [4:0] wa;
    logic       lw;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       use_rs;
    logic       use_rt;
    logic       early;
  } ins_t;

`ifdef HAZARD_STAT_EN
  localparam bit STAT = 1'b1;
`else
  localparam bit STAT = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic [4:0]  id_rs, id_rt, id_wa;
  logic        id_use_rs, id_use_rt, id_early, id_we, id_lw;
  logic        stall;
  logic [1:0]  fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e;
  logic [31:0] stall_cnt;

  hazard_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .id_rs     (id_rs),
    .id_rt     (id_rt),
    .id_use_rs (id_use_rs),
    .id_use_rt (id_use_rt),
    .id_early  (id_early),
    .id_we     (id_we),
    .id_wa     (id_wa),
    .id_lw     (id_lw),
    .stall     (stall),
    .fwd_rs_d  (fwd_rs_d),
    .fwd_rt_d  (fwd_rt_d),
    .fwd_rs_e  (fwd_rs_e),
    .fwd_rt_e  (fwd_rt_e),
    .stall_cnt (stall_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int total = 0;
  int bad   = 0;

  // Model: youngest-first list of instructions that left ID (index 0 = E, 1 = M, 2 = W).
  ins_t        inflight[$];
  logic [31:0] model_cnt;

  logic        obs_stall;
  logic [1:0]  obs_frd, obs_frtd, obs_fre, obs_frte;
  logic [31:0] obs_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic ins_t mk_nop();
    ins_t i;
    i = '0;
    return i;
  endfunction
  function automatic ins_t mk_alu(input logic [4:0] d, input logic [4:0] s, input logic [4:0] t);
    ins_t i;
    i = '0; i.we = 1'b1; i.wa = d; i.rs = s; i.rt = t; i.use_rs = 1'b1; i.use_rt = 1'b1;
    return i;
  endfunction
  function automatic ins_t mk_lw(input logic [4:0] d, input logic [4:0] s);
    ins_t i;
    i = '0; i.we = 1'b1; i.wa = d; i.lw = 1'b1; i.rs = s; i.use_rs = 1'b1;
    return i;
  endfunction
  function automatic ins_t mk_sw(input logic [4:0] s, input logic [4:0] t);
    ins_t i;
    i = '0; i.rs = s; i.rt = t; i.use_rs = 1'b1; i.use_rt = 1'b1;
    return i;
  endfunction
  function automatic ins_t mk_beq(input logic [4:0] s, input logic [4:0] t);
    ins_t i;
    i = mk_sw(s, t); i.early = 1'b1;
    return i;
  endfunction
  function automatic ins_t mk_jr(input logic [4:0] s);
    ins_t i;
    i = '0; i.rs = s; i.use_rs = 1'b1; i.early = 1'b1;
    return i;
  endfunction
  function automatic ins_t mk_jal();
    ins_t i;
    i = '0; i.we = 1'b1; i.wa = 5'd31;
    return i;
  endfunction

  function automatic ins_t rand_ins();
    int k;
    logic [4:0] a, b, c;
    k = int'($urandom_range(0, 6));
    a = 5'($urandom_range(0, 7));
    b = 5'($urandom_range(0, 7));
    c = 5'($urandom_range(0, 7));
    if ($urandom_range(0, 15) == 0) b = 5'd31;
    case (k)
      0: return mk_alu(a, b, c);
      1: return mk_lw(a, b);
      2: return mk_sw(b, c);
      3: return mk_beq(b, c);
      4: return mk_jr(b);
      5: return mk_jal();
      default: return mk_nop();
    endcase
  endfunction

  function automatic ins_t stage_at(input int idx);
    if (idx < inflight.size()) return inflight[idx];
    return '0;
  endfunction

  function automatic logic writes(input ins_t p, input logic [4:0] r);
    return p.we && (p.wa == r) && (r != 5'd0);
  endfunction

  function automatic logic [1:0] fwd_of(input logic u, input logic [4:0] r, input ins_t m, input ins_t w);
    if (!u) return 2'd0;
    if (writes(m, r) && !m.lw) return 2'd1;
    if (writes(w, r)) return 2'd2;
    return 2'd0;
  endfunction

  function automatic logic src_stalls(input ins_t ins, input logic u, input logic [4:0] r);
    ins_t e, m;
    e = stage_at(0);
    m = stage_at(1);
    if (!u) return 1'b0;
    if (writes(e, r) && (ins.early || e.lw)) return 1'b1;
    if (writes(m, r) && m.lw && ins.early) return 1'b1;
    return 1'b0;
  endfunction

  task automatic drive(input ins_t i);
    id_rs = i.rs; id_rt = i.rt; id_use_rs = i.use_rs; id_use_rt = i.use_rt;
    id_early = i.early; id_we = i.we; id_wa = i.wa; id_lw = i.lw;
  endtask

  // One clock with 'ins' in ID: check outputs mid-cycle, then advance the model at the edge.
  task automatic issue(input ins_t ins, output logic st);
    ins_t e, m, w;
    logic es;
    drive(ins);
    @(negedge clk);
    e  = stage_at(0);
    m  = stage_at(1);
    w  = stage_at(2);
    es = src_stalls(ins, ins.use_rs, ins.rs) || src_stalls(ins, ins.use_rt, ins.rt);
    obs_stall = stall; obs_frd = fwd_rs_d; obs_frtd = fwd_rt_d;
    obs_fre = fwd_rs_e; obs_frte = fwd_rt_e; obs_cnt = stall_cnt;
    chk("stall",    32'(stall),    32'(es));
    chk("fwd_rs_d", 32'(fwd_rs_d), 32'(fwd_of(ins.use_rs, ins.rs, m, w)));
    chk("fwd_rt_d", 32'(fwd_rt_d), 32'(fwd_of(ins.use_rt, ins.rt, m, w)));
    chk("fwd_rs_e", 32'(fwd_rs_e), 32'(fwd_of(e.use_rs, e.rs, m, w)));
    chk("fwd_rt_e", 32'(fwd_rt_e), 32'(fwd_of(e.use_rt, e.rt, m, w)));
    chk("stall_cnt", stall_cnt, STAT ? model_cnt : 32'd0);
    @(posedge clk);
    inflight.push_front(es ? mk_nop() : ins);
    if (inflight.size() > 3) void'(inflight.pop_back());
    if (es && (model_cnt != 32'hFFFF_FFFF)) model_cnt++;
    #1;
    st = es;
  endtask

  // Hold 'ins' in ID until it is accepted; returns how many cycles the DUT showed stall.
  task automatic run(input ins_t ins, output int nst);
    logic st;
    int   guard;
    nst   = 0;
    guard = 0;
    do begin
      issue(ins, st);
      if (obs_stall) nst++;
      guard++;
    end while (st && (guard < 4));
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_stall"}, 32'(stall), 32'd0);
    chk({tag, "_frd"},   32'(fwd_rs_d), 32'd0);
    chk({tag, "_frtd"},  32'(fwd_rt_d), 32'd0);
    chk({tag, "_fre"},   32'(fwd_rs_e), 32'd0);
    chk({tag, "_frte"},  32'(fwd_rt_e), 32'd0);
    chk({tag, "_cnt"},   stall_cnt, 32'd0);
  endtask

  initial begin
    int   n;
    logic st;
    model_cnt = '0;
    reset = 1'b1;
    drive(mk_beq(5'd1, 5'd2));
    #12;
    chk_quiet("reset");
    @(posedge clk);
    #1;
    reset = 1'b0;

    // lw $1 ; addu $2,$1,$3 -> one stall, then forward from W into EX.
    run(mk_lw(5'd1, 5'd0), n);
    run(mk_alu(5'd2, 5'd1, 5'd3), n);
    chk("lw_alu_stalls", 32'(n), 32'd1);
    issue(mk_nop(), st);
    chk("lw_alu_fwd_rs_e", 32'(obs_fre), 32'd2);

    // addu $1,$2,$3 ; beq $1,$4 -> one stall, then M forward into ID.
    run(mk_alu(5'd1, 5'd2, 5'd3), n);
    run(mk_beq(5'd1, 5'd4), n);
    chk("alu_beq_stalls", 32'(n), 32'd1);
    chk("alu_beq_fwd_rs_d", 32'(obs_frd), 32'd1);
    chk("alu_beq_release", 32'(obs_stall), 32'd0);

    // lw $5 ; beq $0,$5 -> two stalls, then W forward into ID.
    run(mk_lw(5'd5, 5'd0), n);
    run(mk_beq(5'd0, 5'd5), n);
    chk("lw_beq_stalls", 32'(n), 32'd2);
    chk("lw_beq_fwd_rt_d", 32'(obs_frtd), 32'd2);

    // Register 0 never creates a dependency.
    run(mk_alu(5'd0, 5'd1, 5'd2), n);
    run(mk_alu(5'd3, 5'd0, 5'd0), n);
    chk("r0_alu_stalls", 32'(n), 32'd0);
    run(mk_lw(5'd0, 5'd0), n);
    run(mk_beq(5'd0, 5'd0), n);
    chk("r0_beq_stalls", 32'(n), 32'd0);
    chk("r0_beq_fwd", 32'({obs_frd, obs_frtd}), 32'd0);

    // Two writers of $1: the younger (M) wins over W.
    run(mk_alu(5'd1, 5'd2, 5'd3), n);
    run(mk_alu(5'd1, 5'd2, 5'd3), n);
    run(mk_alu(5'd4, 5'd1, 5'd1), n);
    chk("mw_prio_stalls", 32'(n), 32'd0);
    issue(mk_nop(), st);
    chk("mw_prio_fwd_rs_e", 32'(obs_fre), 32'd1);
    chk("mw_prio_fwd_rt_e", 32'(obs_frte), 32'd1);

    // jal writes $31; jr $31 right behind it must wait one cycle.
    run(mk_jal(), n);
    run(mk_jr(5'd31), n);
    chk("jal_jr_stalls", 32'(n), 32'd1);

    // Reset pulse while a beq is stalled behind a load.
    run(mk_lw(5'd7, 5'd0), n);
    drive(mk_beq(5'd7, 5'd7));
    @(negedge clk);
    chk("pre_rst_stall", 32'(stall), 32'd1);
    #1 reset = 1'b1;
    #1 chk_quiet("rst_mid");
    @(posedge clk);
    #1 chk_quiet("rst_hold");
    reset = 1'b0;
    inflight.delete();
    model_cnt = '0;
    issue(mk_beq(5'd7, 5'd7), st);
    chk("post_rst_stall", 32'(obs_stall), 32'd0);
    run(mk_lw(5'd7, 5'd0), n);
    run(mk_beq(5'd7, 5'd7), n);
    issue(mk_nop(), st);
    chk("lw_beq_cnt", obs_cnt, STAT ? 32'd2 : 32'd0);

    // Random instruction streams against the model.
    for (int i = 0; i < 500; i++) begin
      run(rand_ins(), n);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have port: clk  in  1  pipeline clock, all state updates on rising edge.
REQ-002 SHALL have port: reset  in  1  asynchronous, active-high; clears all stage state.
REQ-003 SHALL have ports: id_rs, id_rt  in  5 each  source register numbers of the instruction in ID.
REQ-004 SHALL have ports: id_use_rs, id_use_rt  in  1 each  ID instruction reads that source.
REQ-005 SHALL have port: id_early  in  1  ID instruction consumes its sources in ID (beq, jr).
REQ-006 SHALL have ports: id_we  in  1, id_wa  in  5, id_lw  in  1  ID instruction writes GRF / dest / is load.
REQ-007 SHALL have port: stall  out  1  freeze PC and IF/ID, insert bubble into ID/EX.
REQ-008 SHALL have ports: fwd_rs_d, fwd_rt_d  out  2 each  ID-stage operand select: 0 GRF, 1 M ALU result, 2 W data.
REQ-009 SHALL have ports: fwd_rs_e, fwd_rt_e  out  2 each  EX-stage operand select, same encoding.
REQ-010 SHALL have port: stall_cnt  out  32  stall-cycle statistic (see Configuration).

Function
REQ-011 SHALL hold three stage records E, M, W: {we, wa, lw, rs, rt, use_rs, use_rt}.
REQ-012 SHALL, each edge: W<=M, M<=E, E<=ID record when stall=0, E<=bubble (all fields 0) when stall=1.
REQ-013 SHALL treat a record as writing r only when we=1, wa==r and r!=0; register 0 never matches.
REQ-014 SHALL assert stall (combinational, same cycle) when id_early and a used source matches E (any writer).
REQ-015 SHALL assert stall when id_early and a used source matches M with M.lw=1.
REQ-016 SHALL assert stall when a used source matches E with E.lw=1 (all instruction types).
REQ-017 SHALL otherwise deassert stall; lw followed by beq on same register yields exactly 2 stall cycles, ALU-op followed by beq exactly 1, lw followed by ALU-op exactly 1.
REQ-018 SHALL drive fwd_*_d = 1 when source matches M and M.lw=0, else 2 when it matches W, else 0; M beats W.
REQ-019 SHALL drive fwd_*_e from E.rs/E.rt: 1 when matching M and M.lw=0, else 2 when matching W, else 0.
REQ-020 SHALL drive fwd outputs to 0 when the corresponding use flag is 0.
REQ-021 SHALL treat jal as id_we=1, id_wa=31, id_lw=0; no special case.

Reset
REQ-022 SHALL, on reset assertion at any time (including mid-stall), immediately clear E, M, W to bubble; stall=0, all fwd=0, stall_cnt=0.
REQ-023 SHALL resume normal tracking on the first rising edge after reset deassertion.

Configuration
REQ-024 SHALL compile the stall counter only when HAZARD_STAT_EN is defined.
REQ-025 SHALL, with HAZARD_STAT_EN: increment stall_cnt by 1 each edge where stall=1, saturating at 0xFFFFFFFF.
REQ-026 SHALL, without HAZARD_STAT_EN: tie stall_cnt to 0 and infer no counter flops.

Structure
REQ-027 SHALL place fwd encodings (FWD_GRF=0, FWD_M=1, FWD_W=2) and the stage-record field widths in the shared pipeline package.
REQ-028 SHALL use one sub-module, hazard_match, comparing one source against one stage record (outputs hit, hit_lw); instantiated per source/stage pair.

Verification
REQ-029 SHALL cover: lw $1; addu $2,$1,$3 -> stall=1 one cycle, then with lw in W and addu in E fwd_rs_e=2.
REQ-030 SHALL cover: addu $1,$2,$3; beq $1,$4 -> stall=1 one cycle, next cycle fwd_rs_d=1, stall=0.
REQ-031 SHALL cover: lw $5; beq $0,$5 -> stall=1 two cycles, third cycle fwd_rt_d=2.
REQ-032 SHALL cover: addu $0,$1,$2; addu $3,$0,$0 and lw $0; beq $0,$0 -> stall=0, all fwd=0 throughout.
REQ-033 SHALL cover: addu $1; addu $1; addu $4,$1,$1 -> fwd_rs_e=fwd_rt_e=1 (M priority over W), no stall.
REQ-034 SHALL cover: reset pulse during lw/beq stall -> stall and fwd drop to 0 asynchronously, stall_cnt=0, bubble state after release; with HAZARD_STAT_EN, stall_cnt=2 after an unreset lw/beq pair.
